// File: rtl/demux_tree_rx_pkg.sv
// Shared definitions for the lane mux/demux tree pair: lane count, slot width
// and the slot-to-lane fill map used on both ends of the serialized link.
package demux_tree_rx_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned SLOT_W     = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  // Tree order is the 2-bit reversal of the slot index: 0,2,1,3.
  function automatic slot_t lane_map(input slot_t slot, input bit tree_order);
    slot_t lane;
    if (tree_order) lane = {slot[0], slot[1]};
    else            lane = slot;
    return lane;
  endfunction

endpackage

// File: rtl/demux_slot_ctrl.sv
// Slot counter, lane-map decode and emit/flush decision for demux_tree_rx.
// wr_en and emit are combinational and describe the current input cycle.
module demux_slot_ctrl
  import demux_tree_rx_pkg::*;
#(
  parameter int TREE_ORDER = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 flush,
  output logic [NUM_LANES-1:0] wr_en,
  output logic                 emit
);

  localparam bit TREE = (TREE_ORDER != 0);

  slot_t count;

  always_comb begin
    wr_en = '0;
    if (valid_in) wr_en[lane_map(count, TREE)] = 1'b1;
    // A flush that coincides with the slot-3 byte folds into the full emit.
    emit = (valid_in && (count == slot_t'(NUM_LANES - 1))) ||
           (flush && ((count != '0) || valid_in));
  end

  always_ff @(posedge clk) begin
    if (reset)         count <= '0;
    else if (emit)     count <= '0;
    else if (valid_in) count <= count + slot_t'(1);
  end

endmodule

// File: rtl/demux_tree_rx.sv
// Deserializes a byte stream back into 4 parallel lanes; staging registers
// collect one group, output registers hold the last emitted group.
module demux_tree_rx
  import demux_tree_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TREE_ORDER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              group_valid
);

  logic [NUM_LANES-1:0] wr_en;
  logic                 emit;

  logic [DATA_W-1:0]    stage   [NUM_LANES];
  logic [NUM_LANES-1:0] stage_v;
  logic [DATA_W-1:0]    data_q  [NUM_LANES];
  logic [NUM_LANES-1:0] valid_q;

  demux_slot_ctrl #(
    .TREE_ORDER(TREE_ORDER)
  ) u_slot_ctrl (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .flush    (flush),
    .wr_en    (wr_en),
    .emit     (emit)
  );

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    // The byte accepted in the emit cycle bypasses staging straight to the output.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage[g]   <= '0;
        stage_v[g] <= 1'b0;
        data_q[g]  <= '0;
        valid_q[g] <= 1'b0;
      end else if (emit) begin
        stage[g]   <= '0;
        stage_v[g] <= 1'b0;
        valid_q[g] <= stage_v[g] | wr_en[g];
        if (wr_en[g])        data_q[g] <= data_in;
        else if (stage_v[g]) data_q[g] <= stage[g];
        else                 data_q[g] <= '0;
      end else if (wr_en[g]) begin
        stage[g]   <= data_in;
        stage_v[g] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) group_valid <= 1'b0;
    else       group_valid <= emit;
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];

endmodule

// File: tb/tb_demux_tree_rx.sv
// Bench for demux_tree_rx: a tree-order and a linear-order instance share one
// stimulus stream and are checked each cycle against a group-level model.
module tb_demux_tree_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       flush;

  logic [7:0] t_d0, t_d1, t_d2, t_d3, l_d0, l_d1, l_d2, l_d3;
  logic       t_v0, t_v1, t_v2, t_v3, l_v0, l_v1, l_v2, l_v3;
  logic       t_gv, l_gv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_tree_rx #(.DATA_W(8), .TREE_ORDER(1)) dut_tree (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .data_out0(t_d0), .data_out1(t_d1), .data_out2(t_d2), .data_out3(t_d3),
    .valid_out0(t_v0), .valid_out1(t_v1), .valid_out2(t_v2), .valid_out3(t_v3),
    .group_valid(t_gv)
  );

  demux_tree_rx #(.DATA_W(8), .TREE_ORDER(0)) dut_lin (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .data_out0(l_d0), .data_out1(l_d1), .data_out2(l_d2), .data_out3(l_d3),
    .valid_out0(l_v0), .valid_out1(l_v1), .valid_out2(l_v2), .valid_out3(l_v3),
    .group_valid(l_gv)
  );

  // Model: collect accepted bytes of a group in arrival order, place them on
  // emit. Index 0 = tree order instance, 1 = linear order instance.
  int         tree_lane [4] = '{0, 2, 1, 3};
  logic [7:0] gbuf [4];
  int         gcnt = 0;
  logic [7:0] exp_d [2][4];
  logic       exp_v [2][4];
  logic       exp_gv [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_gv[i] = 1'b0;
      for (int l = 0; l < 4; l++) begin exp_d[i][l] = '0; exp_v[i][l] = 1'b0; end
    end
  end

  always @(posedge clk) begin
    exp_gv[0] = 1'b0;
    exp_gv[1] = 1'b0;
    if (reset) begin
      gcnt = 0;
      for (int i = 0; i < 2; i++)
        for (int l = 0; l < 4; l++) begin exp_d[i][l] = '0; exp_v[i][l] = 1'b0; end
    end else begin
      if (valid_in) begin
        gbuf[gcnt] = data_in;
        gcnt++;
      end
      if (gcnt == 4 || (flush && gcnt > 0)) begin
        for (int i = 0; i < 2; i++) begin
          for (int l = 0; l < 4; l++) begin exp_d[i][l] = '0; exp_v[i][l] = 1'b0; end
          for (int k = 0; k < gcnt; k++) begin
            int lane;
            lane = (i == 0) ? tree_lane[k] : k;
            exp_d[i][lane] = gbuf[k];
            exp_v[i][lane] = 1'b1;
          end
          exp_gv[i] = 1'b1;
        end
        gcnt = 0;
      end
    end
  end

  logic [7:0] act_d [2][4];
  logic       act_v [2][4];
  logic       act_gv [2];
  assign act_d[0][0] = t_d0; assign act_d[0][1] = t_d1; assign act_d[0][2] = t_d2; assign act_d[0][3] = t_d3;
  assign act_d[1][0] = l_d0; assign act_d[1][1] = l_d1; assign act_d[1][2] = l_d2; assign act_d[1][3] = l_d3;
  assign act_v[0][0] = t_v0; assign act_v[0][1] = t_v1; assign act_v[0][2] = t_v2; assign act_v[0][3] = t_v3;
  assign act_v[1][0] = l_v0; assign act_v[1][1] = l_v1; assign act_v[1][2] = l_v2; assign act_v[1][3] = l_v3;
  assign act_gv[0] = t_gv;
  assign act_gv[1] = l_gv;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gv[i] !== exp_gv[i]) begin
        errors++;
        $display("FAIL model_gv[%0d] t=%0t: got %b expected %b", i, $time, act_gv[i], exp_gv[i]);
      end
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (act_d[i][l] !== exp_d[i][l] || act_v[i][l] !== exp_v[i][l]) begin
          errors++;
          $display("FAIL model_lane[%0d][%0d] t=%0t: got d=%h v=%b expected d=%h v=%b",
                   i, l, $time, act_d[i][l], act_v[i][l], exp_d[i][l], exp_v[i][l]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] tvec();
    return {t_v3, t_v2, t_v1, t_v0};
  endfunction

  function automatic logic [3:0] lvec();
    return {l_v3, l_v2, l_v1, l_v0};
  endfunction

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_gv", {31'd0, t_gv}, 32'd0);
    chk("reset_out0", {24'd0, t_d0}, 32'd0);
    chk("reset_valid", {28'd0, tvec()}, 32'd0);
    reset = 1'b0;
    step(0, 8'h00, 0);

    // Full tree-order group
    step(1, 8'hA0, 0); step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(1, 8'hA3, 0);
    chk("t1_gv", {31'd0, t_gv}, 32'd1);
    chk("t1_out0", {24'd0, t_d0}, 32'hA0);
    chk("t1_out2", {24'd0, t_d2}, 32'hA1);
    chk("t1_out1", {24'd0, t_d1}, 32'hA2);
    chk("t1_out3", {24'd0, t_d3}, 32'hA3);
    chk("t1_valid", {28'd0, tvec()}, 32'hF);
    step(0, 8'h00, 0);
    chk("t1_gv_drop", {31'd0, t_gv}, 32'd0);

    // Back-to-back linear groups
    for (int k = 0; k < 8; k++) begin
      step(1, 8'h10 + 8'(k), 0);
      if (k == 3) chk("t2_first", {l_d3, l_d2, l_d1, l_d0}, 32'h13121110);
      if (k == 5) begin
        chk("t2_hold", {l_d3, l_d2, l_d1, l_d0}, 32'h13121110);
        chk("t2_hold_gv", {31'd0, l_gv}, 32'd0);
      end
    end
    chk("t2_second", {l_d3, l_d2, l_d1, l_d0}, 32'h17161514);
    chk("t2_second_gv", {31'd0, l_gv}, 32'd1);
    step(0, 8'h00, 0);

    // Bubbles between bytes
    step(1, 8'h55, 0); step(0, 8'h00, 0); step(0, 8'h00, 0);
    step(1, 8'h66, 0); step(0, 8'h00, 0); step(1, 8'h77, 0);
    chk("t3_no_emit", {31'd0, t_gv}, 32'd0);
    step(1, 8'h88, 0);
    chk("t3_tree", {t_d3, t_d2, t_d1, t_d0}, 32'h88667755);
    chk("t3_gv", {31'd0, t_gv}, 32'd1);
    step(0, 8'h00, 0);

    // Partial flush
    step(1, 8'hC1, 0); step(1, 8'hC2, 0); step(0, 8'h00, 1);
    chk("t4_gv", {31'd0, t_gv}, 32'd1);
    chk("t4_data", {t_d3, t_d2, t_d1, t_d0}, 32'h00C200C1);
    chk("t4_valid", {28'd0, tvec()}, 32'h5);
    chk("t4_lin_data", {l_d3, l_d2, l_d1, l_d0}, 32'h0000C2C1);
    step(1, 8'hD0, 1);
    chk("t4_next_lane0", {t_d3, t_d2, t_d1, t_d0}, 32'h000000D0);
    chk("t4_next_valid", {28'd0, tvec()}, 32'h1);

    // Empty flush, then flush with the 4th byte
    step(0, 8'h00, 1);
    chk("t5_empty_flush", {31'd0, t_gv}, 32'd0);
    chk("t5_empty_hold", {28'd0, tvec()}, 32'h1);
    step(1, 8'hB0, 0); step(1, 8'hB1, 0); step(1, 8'hB2, 0); step(1, 8'hB3, 1);
    chk("t5_full_gv", {31'd0, l_gv}, 32'd1);
    chk("t5_full_data", {l_d3, l_d2, l_d1, l_d0}, 32'hB3B2B1B0);
    chk("t5_full_valid", {28'd0, lvec()}, 32'hF);
    step(0, 8'h00, 1);
    chk("t5_once", {31'd0, l_gv}, 32'd0);

    // Reset mid-group
    step(1, 8'h31, 0); step(1, 8'h32, 0); step(1, 8'h33, 0);
    reset = 1'b1;
    step(0, 8'h00, 0);
    reset = 1'b0;
    chk("t6_reset_data", {t_d3, t_d2, t_d1, t_d0}, 32'd0);
    chk("t6_reset_valid", {27'd0, t_gv, tvec()}, 32'd0);
    step(1, 8'hE0, 0);
    chk("t6_no_emit", {31'd0, t_gv}, 32'd0);
    step(1, 8'hE1, 0); step(1, 8'hE2, 0); step(1, 8'hE3, 0);
    chk("t6_tree", {t_d3, t_d2, t_d1, t_d0}, 32'hE3E1E2E0);
    chk("t6_lin", {l_d3, l_d2, l_d1, l_d0}, 32'hE3E2E1E0);
    chk("t6_gv", {31'd0, t_gv}, 32'd1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
